// File: rtl/counter_n_pulse.sv
// Loadable down-counter that emits a registered one-cycle pulse on terminal count.
// Supports one-shot or periodic reload, count enable, abort, and optional retrigger.
module counter_n_pulse #(
  parameter int WIDTH     = 8,
  parameter bit RETRIGGER = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             mode,
  input  logic             stop,
  input  logic [WIDTH-1:0] load,
  output logic             pulse,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] count_nx;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_nx;
  logic             mode_reg;
  logic             mode_nx;
  logic             pulse_nx;
  logic             load_ok;
  logic             accept_start;
  logic             terminal;

  assign load_ok      = (load != '0);
  assign accept_start = start && load_ok && ((state == IDLE) || RETRIGGER);
  assign terminal     = (count == WIDTH'(1));

  // Registered state; reset drops the pulse without waiting for an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      mode_reg   <= 1'b0;
      pulse      <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      reload_reg <= reload_nx;
      mode_reg   <= mode_nx;
      pulse      <= pulse_nx;
    end
  end

  // Edge priority is stop, then start, then countdown; a rejected start
  // falls through so a running count keeps going.
  always_comb begin
    state_nx  = state;
    count_nx  = count;
    reload_nx = reload_reg;
    mode_nx   = mode_reg;
    pulse_nx  = 1'b0;
    if (stop) begin
      state_nx = IDLE;
      count_nx = '0;
    end else if (accept_start) begin
      state_nx  = RUN;
      count_nx  = load;
      reload_nx = load;
      mode_nx   = mode;
    end else if ((state == RUN) && en) begin
      if (terminal) begin
        pulse_nx = 1'b1;
        if (mode_reg) begin
          count_nx = reload_reg;
        end else begin
          count_nx = '0;
          state_nx = IDLE;
        end
      end else begin
        count_nx = count - WIDTH'(1);
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_counter_n_pulse.sv
// Bench for counter_n_pulse: three instances (8-bit retrigger, 8-bit no retrigger, 12-bit)
// share stimulus; a pulse-time scoreboard checks the selected instance.
module tb_counter_n_pulse;

  logic        clk;
  logic        rst;
  logic        en;
  logic        start;
  logic        mode;
  logic        stop;
  logic [11:0] load;

  logic        pulse_a, busy_a;
  logic [7:0]  count_a;
  logic        pulse_b, busy_b;
  logic [7:0]  count_b;
  logic        pulse_c, busy_c;
  logic [11:0] count_c;

  int          sel;
  logic        cur_pulse, cur_busy;
  logic [11:0] cur_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_q[$];

  counter_n_pulse #(.WIDTH(8), .RETRIGGER(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .stop(stop),
    .load(load[7:0]), .pulse(pulse_a), .busy(busy_a), .count(count_a));

  counter_n_pulse #(.WIDTH(8), .RETRIGGER(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .stop(stop),
    .load(load[7:0]), .pulse(pulse_b), .busy(busy_b), .count(count_b));

  counter_n_pulse #(.WIDTH(12), .RETRIGGER(1'b1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .stop(stop),
    .load(load), .pulse(pulse_c), .busy(busy_c), .count(count_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (sel)
      1:       begin cur_pulse = pulse_b; cur_busy = busy_b; cur_count = {4'b0, count_b}; end
      2:       begin cur_pulse = pulse_c; cur_busy = busy_c; cur_count = count_c; end
      default: begin cur_pulse = pulse_a; cur_busy = busy_a; cur_count = {4'b0, count_a}; end
    endcase
  end

  // Pulse scoreboard: every observed pulse must match the oldest expected cycle,
  // and an expected cycle that passes without a pulse is reported as missed.
  always @(negedge clk) begin
    int e;
    if (rst) begin
      if (cur_pulse) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL pulse_unexpected dut=%0d cycle=%0d want=no pulse", sel, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e !== cyc) begin
            errors++;
            $display("[TB] FAIL pulse_time dut=%0d got cycle=%0d want cycle=%0d", sel, cyc, e);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0] <= cyc) begin
        checks++;
        errors++;
        e = exp_q.pop_front();
        $display("[TB] FAIL pulse_missed dut=%0d got none at cycle=%0d want cycle=%0d", sel, cyc, e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_until(input int t);
    int guard = 0;
    while (cyc < t && guard < 10000) begin
      step(1);
      guard++;
    end
    checks++;
    if (cyc !== t) begin
      errors++;
      $display("[TB] FAIL wait_until got cycle=%0d want cycle=%0d", cyc, t);
    end
  endtask

  task automatic idle_all();
    start = 1'b0;
    en    = 1'b1;
    stop  = 1'b1;
    step(1);
    stop  = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; load = 12'd15; en = 1'b1; mode = 1'b0; stop = 1'b0; sel = 0;
    repeat (2) begin
      step(1);
      checks++;
      if ({pulse_a, busy_a, count_a} !== 10'd0) begin
        errors++;
        $display("[TB] FAIL reset_a got p=%0b b=%0b c=%0d want 0/0/0", pulse_a, busy_a, count_a);
      end
      checks++;
      if ({pulse_b, busy_b, count_b} !== 10'd0) begin
        errors++;
        $display("[TB] FAIL reset_b got p=%0b b=%0b c=%0d want 0/0/0", pulse_b, busy_b, count_b);
      end
      checks++;
      if ({pulse_c, busy_c, count_c} !== 14'd0) begin
        errors++;
        $display("[TB] FAIL reset_c got p=%0b b=%0b c=%0d want 0/0/0", pulse_c, busy_c, count_c);
      end
    end
    start = 1'b0;
    rst   = 1'b1;
    step(3);
    checks++;
    if ({busy_a, busy_b, busy_c, count_a, count_b, count_c} !== 31'd0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle got busy=%0b%0b%0b counts=%0d/%0d/%0d want all 0",
               busy_a, busy_b, busy_c, count_a, count_b, count_c);
    end
  endtask

  task automatic test_one_shot();
    int s;
    idle_all();
    sel = 0; load = 12'd15; mode = 1'b0; start = 1'b1;
    s = cyc + 1;
    exp_q.push_back(s + 15);
    step(1);
    start = 1'b0;
    checks++;
    if (cur_busy !== 1'b1 || cur_count !== 12'd15) begin
      errors++;
      $display("[TB] FAIL oneshot_arm got busy=%0b count=%0d want busy=1 count=15", cur_busy, cur_count);
    end
    for (int k = 1; k < 15; k++) begin
      step(1);
      checks++;
      if (cur_count !== 12'(15 - k)) begin
        errors++;
        $display("[TB] FAIL oneshot_count got=%0d want=%0d", cur_count, 15 - k);
      end
    end
    step(1);
    checks++;
    if (cur_busy !== 1'b0 || cur_count !== 12'd0) begin
      errors++;
      $display("[TB] FAIL oneshot_done got busy=%0b count=%0d want busy=0 count=0", cur_busy, cur_count);
    end
    step(40);
    checks++;
    if (exp_q.size() !== 0 || cur_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oneshot_quiet got pending=%0d busy=%0b want pending=0 busy=0", exp_q.size(), cur_busy);
    end
  endtask

  task automatic test_periodic_gaps();
    int s;
    idle_all();
    sel = 0; load = 12'd4; mode = 1'b1; start = 1'b1;
    s = cyc + 1;
    exp_q.push_back(s + 4);
    exp_q.push_back(s + 8);
    exp_q.push_back(s + 15);
    exp_q.push_back(s + 19);
    step(1);
    start = 1'b0;
    wait_until(s + 8);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if (cur_count !== 12'd4 || cur_busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL gap_freeze got count=%0d busy=%0b want count=4 busy=1", cur_count, cur_busy);
      end
    end
    en = 1'b1;
    wait_until(s + 19);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    checks++;
    if (cur_busy !== 1'b0 || cur_count !== 12'd0 || exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL periodic_stop got busy=%0b count=%0d pending=%0d want 0/0/0",
               cur_busy, cur_count, exp_q.size());
    end
  endtask

  task automatic test_stop_retrigger();
    int s;
    idle_all();
    sel = 0; load = 12'd10; mode = 1'b1; start = 1'b1;
    s = cyc + 1;
    step(1);
    start = 1'b0;
    wait_until(s + 7);
    checks++;
    if (cur_count !== 12'd3) begin
      errors++;
      $display("[TB] FAIL stop_precount got=%0d want=3", cur_count);
    end
    stop = 1'b1; start = 1'b1; load = 12'd10;
    step(1);
    stop = 1'b0; start = 1'b0;
    checks++;
    if (cur_busy !== 1'b0 || cur_count !== 12'd0) begin
      errors++;
      $display("[TB] FAIL stop_start got busy=%0b count=%0d want busy=0 count=0", cur_busy, cur_count);
    end
    step(12);
    for (int d = 0; d < 2; d++) begin
      idle_all();
      sel = d; load = 12'd10; mode = 1'b1; start = 1'b1;
      s = cyc + 1;
      step(1);
      start = 1'b0;
      wait_until(s + 5);
      checks++;
      if (cur_count !== 12'd5) begin
        errors++;
        $display("[TB] FAIL retrig_precount dut=%0d got=%0d want=5", d, cur_count);
      end
      start = 1'b1; load = 12'd6;
      exp_q.push_back((d == 0) ? s + 12 : s + 10);
      step(1);
      start = 1'b0; load = 12'd10;
      checks++;
      if (cur_count !== ((d == 0) ? 12'd6 : 12'd4)) begin
        errors++;
        $display("[TB] FAIL retrig_count dut=%0d got=%0d want=%0d", d, cur_count, (d == 0) ? 6 : 4);
      end
      wait_until((d == 0) ? s + 12 : s + 10);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      checks++;
      if (exp_q.size() !== 0) begin
        errors++;
        $display("[TB] FAIL retrig_pending dut=%0d got=%0d want=0", d, exp_q.size());
      end
    end
  endtask

  task automatic test_boundaries();
    int s;
    idle_all();
    sel = 0; load = 12'd0; mode = 1'b1; start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (cur_busy !== 1'b0 || cur_count !== 12'd0) begin
      errors++;
      $display("[TB] FAIL load0_idle got busy=%0b count=%0d want busy=0 count=0", cur_busy, cur_count);
    end
    step(2);
    load = 12'd1; start = 1'b1;
    s = cyc + 1;
    for (int i = 1; i <= 9; i++) exp_q.push_back(s + i);
    step(1);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      checks++;
      if (cur_pulse !== 1'b1) begin
        errors++;
        $display("[TB] FAIL load1_continuous got=%0b want=1 at cycle=%0d", cur_pulse, cyc);
      end
    end
    start = 1'b1; load = 12'd0;
    step(1);
    start = 1'b0;
    checks++;
    if (cur_pulse !== 1'b1 || cur_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL run_load0_ignored got pulse=%0b busy=%0b want 1/1", cur_pulse, cur_busy);
    end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    checks++;
    if (cur_pulse !== 1'b0 || cur_busy !== 1'b0 || exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL load1_stop got pulse=%0b busy=%0b pending=%0d want 0/0/0",
               cur_pulse, cur_busy, exp_q.size());
    end
    idle_all();
    sel = 2; load = 12'd4095; mode = 1'b0; start = 1'b1;
    s = cyc + 1;
    exp_q.push_back(s + 4095);
    step(1);
    start = 1'b0;
    checks++;
    if (cur_count !== 12'd4095) begin
      errors++;
      $display("[TB] FAIL max_load got=%0d want=4095", cur_count);
    end
    wait_until(s + 4095);
    checks++;
    if (cur_busy !== 1'b0 || cur_count !== 12'd0) begin
      errors++;
      $display("[TB] FAIL max_done got busy=%0b count=%0d want busy=0 count=0", cur_busy, cur_count);
    end
    step(5);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL max_pending got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    int s;
    idle_all();
    sel = 0; load = 12'd7; mode = 1'b1; start = 1'b1;
    s = cyc + 1;
    exp_q.push_back(s + 7);
    step(1);
    start = 1'b0;
    wait_until(s + 7);
    checks++;
    if (cur_pulse !== 1'b1 || cur_count !== 12'd7) begin
      errors++;
      $display("[TB] FAIL async_pre got pulse=%0b count=%0d want pulse=1 count=7", cur_pulse, cur_count);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (cur_pulse !== 1'b0 || cur_busy !== 1'b0 || cur_count !== 12'd0) begin
      errors++;
      $display("[TB] FAIL async_clear got pulse=%0b busy=%0b count=%0d want 0/0/0",
               cur_pulse, cur_busy, cur_count);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    step(3);
    checks++;
    if (cur_busy !== 1'b0 || cur_count !== 12'd0) begin
      errors++;
      $display("[TB] FAIL async_after got busy=%0b count=%0d want busy=0 count=0", cur_busy, cur_count);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_one_shot();
    test_periodic_gaps();
    test_stop_retrigger();
    test_boundaries();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_n_pulse.md
Name: counter_n_pulse

Overview:
- Parametrised successor to the team's fixed 8-bit loadable pulse counter.
- Loads a WIDTH-bit period, counts down and emits a one-cycle registered pulse on terminal count.
- Adds one-shot/periodic mode, count enable, stop and optional retrigger.
- Used as a programmable tick/timeout generator feeding downstream one-shot and level-detect logic.

Parameters:
- WIDTH, 8: width of load and count.
- RETRIGGER, 1: when 1, start while running reloads; when 0, start is ignored while busy.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
- en  input  1  count enable; 0 freezes count.
- start  input  1  sampled each edge; arms the counter with load.
- mode  input  1  sampled with start; 0 = one-shot, 1 = periodic.
- stop  input  1  abort; returns to IDLE.
- load  input  WIDTH  period in clock cycles; 0 is illegal.
- pulse  output  1  registered one-cycle terminal-count pulse.
- busy  output  1  high while in RUN.
- count  output  WIDTH  current remaining count.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, count=0, reload_reg=0, mode_reg=0. Outputs pulse=0, busy=0.
- State machine: IDLE, RUN. busy = (state==RUN), registered.
- Per-edge priority: stop > start > countdown.
- IDLE:
  - start=1 and load!=0 → RUN, count<=load, reload_reg<=load, mode_reg<=mode.
  - start=1 and load==0 → ignored; stays IDLE, count unchanged.
- RUN, stop=1: → IDLE, count<=0, pulse<=0. stop also cancels a pulse that would fire on the same edge.
- RUN, start=1 and RETRIGGER=1:
  - load!=0: count<=load, reload_reg/mode_reg re-sampled, pulse<=0.
  - load==0: start ignored; countdown continues.
- RUN, start=1 and RETRIGGER=0: start ignored.
- RUN, en=0: count and state hold; pulse<=0.
- RUN, en=1, count>1: count<=count-1, pulse<=0.
- RUN, en=1, count==1 (terminal): pulse<=1.
  - mode_reg=1: count<=reload_reg, stay RUN.
  - mode_reg=0: count<=0, → IDLE.
- pulse is 0 on every edge not listed as terminal. It is never combinational.
- Latency: with en held high, pulse is high in the cycle following the N-th edge after the start edge (N = load). Periodic repeat interval is exactly N cycles.
- load=1 in periodic mode: pulse high every cycle (continuous). This is legal.
- en deasserted for K cycles stretches the period by exactly K cycles.
- Arithmetic: unsigned, WIDTH bits. No wrap, since count never decrements from 0.
- Maximum period: 2^WIDTH-1.
- Reset mid-RUN: immediate return to the reset state; pulse drops asynchronously.

Test Plan:
1. Reset: rst=0 for 2 cycles with start=1, load=15 → pulse=0, busy=0, count=0 throughout. Release rst, idle 3 cycles → no activity.
2. One-shot: load=15, mode=0, start one cycle, en=1 → busy high from the next edge. Exactly one pulse, in the 15th cycle after the start edge. Then busy=0, count=0, and no further pulses over 40 cycles.
3. Periodic with enable gaps: WIDTH=8, load=4, mode=1, en=1 → pulses at cycles 4, 8, 12. Drop en for 3 cycles after the 2nd pulse → 3rd pulse moves to cycle 15, count frozen during the gap.
4. Stop and retrigger: load=10, periodic. At count=3 assert stop and start together → IDLE, no pulse. Rearm with load=10; at count=5 pulse start with load=6 → next pulse 6 cycles later (RETRIGGER=1). Repeat with RETRIGGER=0 → pulse at the original 10.
5. Boundaries: start with load=0 → stays IDLE. load=1 periodic → pulse continuously high. WIDTH=12, load=4095 one-shot → single pulse after 4095 cycles.
6. Async reset mid-run: drop rst between edges while count=7 → pulse, busy and count clear without waiting for a clock edge.
